// File: rtl/decode_queue.sv
// Decode queue: DEPTH-entry instruction FIFO feeding a registered RV32I/RV64I decoder.
package decode_queue_pkg;
  localparam logic [5:0]
    i_invalid = 6'd0,  i_lui    = 6'd1,  i_auipc  = 6'd2,  i_jal    = 6'd3,  i_jalr   = 6'd4,
    i_beq     = 6'd5,  i_bne    = 6'd6,  i_blt    = 6'd7,  i_bge    = 6'd8,  i_bltu   = 6'd9,
    i_bgeu    = 6'd10, i_lb     = 6'd11, i_lh     = 6'd12, i_lw     = 6'd13, i_lbu    = 6'd14,
    i_lhu     = 6'd15, i_sb     = 6'd16, i_sh     = 6'd17, i_sw     = 6'd18, i_addi   = 6'd19,
    i_slti    = 6'd20, i_sltiu  = 6'd21, i_xori   = 6'd22, i_ori    = 6'd23, i_andi   = 6'd24,
    i_slli    = 6'd25, i_srli   = 6'd26, i_srai   = 6'd27, i_add    = 6'd28, i_sub    = 6'd29,
    i_sll     = 6'd30, i_slt    = 6'd31, i_sltu   = 6'd32, i_xor    = 6'd33, i_srl    = 6'd34,
    i_sra     = 6'd35, i_or     = 6'd36, i_and    = 6'd37, i_fence  = 6'd38, i_ecall  = 6'd39,
    i_ebreak  = 6'd40, i_csrrw  = 6'd41, i_csrrs  = 6'd42, i_csrrc  = 6'd43, i_csrrwi = 6'd44,
    i_csrrsi  = 6'd45, i_csrrci = 6'd46, i_ld     = 6'd47, i_lwu    = 6'd48, i_sd     = 6'd49;
endpackage

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_func3,
  output logic [6:0]      out_func7,
  output logic [5:0]      out_shamt,
  output logic [XLEN-1:0] out_imm,
  output logic [5:0]      out_instr_id,
  output logic            out_illegal,
  output logic [CW-1:0]   count
);
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned EW   = XLEN + 32;
  localparam bit          RV64 = (XLEN == 64);

  logic [EW-1:0]   mem_q [DEPTH];
  logic [EW-1:0]   mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d, out_imm_q, out_imm_d;
  logic [6:0]      out_opcode_q, out_opcode_d, out_func7_q, out_func7_d;
  logic [4:0]      out_rd_q, out_rd_d, out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d;
  logic [2:0]      out_func3_q, out_func3_d;
  logic [5:0]      out_shamt_q, out_shamt_d, out_instr_id_q, out_instr_id_d;
  logic            out_illegal_q, out_illegal_d;

  logic            push, load, sh_zero, sh_sra;
  logic [31:0]     hd_instr;
  logic [XLEN-1:0] hd_pc, dec_imm, imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [5:0]      dec_id, dec_shamt;

  assign push = in_valid && in_ready_q && !flush;
  assign load = (count_q != '0) && (!out_valid_q || out_ready) && !flush;

  // Combinational decode of the FIFO head
  always_comb begin
    {hd_pc, hd_instr} = mem_q[rd_ptr_q];
    sh_zero   = RV64 ? (hd_instr[31:26] == 6'b000000) : (hd_instr[31:25] == 7'b0000000);
    sh_sra    = RV64 ? (hd_instr[31:26] == 6'b010000) : (hd_instr[31:25] == 7'b0100000);
    dec_shamt = RV64 ? hd_instr[25:20] : {1'b0, hd_instr[24:20]};
    imm_i = XLEN'($signed(hd_instr[31:20]));
    imm_s = XLEN'($signed({hd_instr[31:25], hd_instr[11:7]}));
    imm_b = XLEN'($signed({hd_instr[31], hd_instr[7], hd_instr[30:25], hd_instr[11:8], 1'b0}));
    imm_j = XLEN'($signed({hd_instr[31], hd_instr[19:12], hd_instr[20], hd_instr[30:21], 1'b0}));
    imm_u = XLEN'($signed({hd_instr[31:12], 12'b0}));
    dec_id  = i_invalid;
    dec_imm = '0;
    case (hd_instr[6:0])
      7'b0110111: begin dec_id = i_lui;   dec_imm = imm_u; end
      7'b0010111: begin dec_id = i_auipc; dec_imm = imm_u; end
      7'b1101111: begin dec_id = i_jal;   dec_imm = imm_j; end
      7'b1100111: begin
        dec_imm = imm_i;
        if (hd_instr[14:12] == 3'b000) dec_id = i_jalr;
      end
      7'b1100011: begin
        dec_imm = imm_b;
        case (hd_instr[14:12])
          3'b000: dec_id = i_beq;   3'b001: dec_id = i_bne;
          3'b100: dec_id = i_blt;   3'b101: dec_id = i_bge;
          3'b110: dec_id = i_bltu;  3'b111: dec_id = i_bgeu;
          default: ;
        endcase
      end
      7'b0000011: begin
        dec_imm = imm_i;
        case (hd_instr[14:12])
          3'b000: dec_id = i_lb;    3'b001: dec_id = i_lh;
          3'b010: dec_id = i_lw;    3'b100: dec_id = i_lbu;
          3'b101: dec_id = i_lhu;
          3'b011: if (RV64) dec_id = i_ld;
          3'b110: if (RV64) dec_id = i_lwu;
          default: ;
        endcase
      end
      7'b0100011: begin
        dec_imm = imm_s;
        case (hd_instr[14:12])
          3'b000: dec_id = i_sb;    3'b001: dec_id = i_sh;
          3'b010: dec_id = i_sw;
          3'b011: if (RV64) dec_id = i_sd;
          default: ;
        endcase
      end
      7'b0010011: begin
        dec_imm = imm_i;
        case (hd_instr[14:12])
          3'b000: dec_id = i_addi;  3'b010: dec_id = i_slti;
          3'b011: dec_id = i_sltiu; 3'b100: dec_id = i_xori;
          3'b110: dec_id = i_ori;   3'b111: dec_id = i_andi;
          3'b001: if (sh_zero) dec_id = i_slli;
          3'b101: begin
            if (sh_zero)     dec_id = i_srli;
            else if (sh_sra) dec_id = i_srai;
          end
          default: ;
        endcase
      end
      7'b0110011: begin
        case ({hd_instr[31:25], hd_instr[14:12]})
          {7'h00, 3'b000}: dec_id = i_add;  {7'h20, 3'b000}: dec_id = i_sub;
          {7'h00, 3'b001}: dec_id = i_sll;  {7'h00, 3'b010}: dec_id = i_slt;
          {7'h00, 3'b011}: dec_id = i_sltu; {7'h00, 3'b100}: dec_id = i_xor;
          {7'h00, 3'b101}: dec_id = i_srl;  {7'h20, 3'b101}: dec_id = i_sra;
          {7'h00, 3'b110}: dec_id = i_or;   {7'h00, 3'b111}: dec_id = i_and;
          default: ;
        endcase
      end
      7'b0001111: begin
        dec_imm = imm_i;
        if (hd_instr[14:12] == 3'b000) dec_id = i_fence;
      end
      7'b1110011: begin
        dec_imm = imm_i;
        case (hd_instr[14:12])
          3'b000: begin
            if (hd_instr[31:7] == 25'd0) dec_id = i_ecall;
            else if (hd_instr[31:20] == 12'd1 && hd_instr[19:7] == 13'd0) dec_id = i_ebreak;
          end
          3'b001: dec_id = i_csrrw;  3'b010: dec_id = i_csrrs;
          3'b011: dec_id = i_csrrc;  3'b101: dec_id = i_csrrwi;
          3'b110: dec_id = i_csrrsi; 3'b111: dec_id = i_csrrci;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Next state: flush first, then push at tail and load/pop of head into output register
  always_comb begin
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    out_valid_d    = out_valid_q;
    out_pc_d       = out_pc_q;
    out_opcode_d   = out_opcode_q;
    out_rd_d       = out_rd_q;
    out_rs1_d      = out_rs1_q;
    out_rs2_d      = out_rs2_q;
    out_func3_d    = out_func3_q;
    out_func7_d    = out_func7_q;
    out_shamt_d    = out_shamt_q;
    out_imm_d      = out_imm_q;
    out_instr_id_d = out_instr_id_q;
    out_illegal_d  = out_illegal_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {in_pc, in_instr};
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (load) begin
        rd_ptr_d       = rd_ptr_q + PW'(1);
        out_valid_d    = 1'b1;
        out_pc_d       = hd_pc;
        out_opcode_d   = hd_instr[6:0];
        out_rd_d       = hd_instr[11:7];
        out_rs1_d      = hd_instr[19:15];
        out_rs2_d      = hd_instr[24:20];
        out_func3_d    = hd_instr[14:12];
        out_func7_d    = hd_instr[31:25];
        out_shamt_d    = dec_shamt;
        out_imm_d      = dec_imm;
        out_instr_id_d = dec_id;
        out_illegal_d  = (dec_id == i_invalid);
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      count_d = count_q + CW'(push) - CW'(load);
    end
    in_ready_d = (count_d != CW'(DEPTH));
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      out_pc_q       <= '0;
      out_opcode_q   <= '0;
      out_rd_q       <= '0;
      out_rs1_q      <= '0;
      out_rs2_q      <= '0;
      out_func3_q    <= '0;
      out_func7_q    <= '0;
      out_shamt_q    <= '0;
      out_imm_q      <= '0;
      out_instr_id_q <= '0;
      out_illegal_q  <= 1'b0;
    end else begin
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
      out_pc_q       <= out_pc_d;
      out_opcode_q   <= out_opcode_d;
      out_rd_q       <= out_rd_d;
      out_rs1_q      <= out_rs1_d;
      out_rs2_q      <= out_rs2_d;
      out_func3_q    <= out_func3_d;
      out_func7_q    <= out_func7_d;
      out_shamt_q    <= out_shamt_d;
      out_imm_q      <= out_imm_d;
      out_instr_id_q <= out_instr_id_d;
      out_illegal_q  <= out_illegal_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign out_opcode   = out_opcode_q;
  assign out_rd       = out_rd_q;
  assign out_rs1      = out_rs1_q;
  assign out_rs2      = out_rs2_q;
  assign out_func3    = out_func3_q;
  assign out_func7    = out_func7_q;
  assign out_shamt    = out_shamt_q;
  assign out_imm      = out_imm_q;
  assign out_instr_id = out_instr_id_q;
  assign out_illegal  = out_illegal_q;
  assign count        = count_q;
endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: XLEN=32 and XLEN=64 instances share stimulus; a queue model plus
// an opcode mask/match table predict every output.
module tb_decode_queue;
  import decode_queue_pkg::*;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic        clk = 1'b0;
  logic        rst_n, in_valid, flush, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic a_in_ready, a_out_valid, a_illegal, b_in_ready, b_out_valid, b_illegal;
  logic [31:0] a_pc, a_imm;
  logic [63:0] b_pc, b_imm;
  logic [6:0]  a_opcode, a_func7, b_opcode, b_func7;
  logic [4:0]  a_rd, a_rs1, a_rs2, b_rd, b_rs1, b_rs2;
  logic [2:0]  a_func3, b_func3;
  logic [5:0]  a_shamt, a_id, b_shamt, b_id;
  logic [CW-1:0] a_count, b_count;

  always #5 clk = ~clk;

  decode_queue #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
    .in_pc(in_pc[31:0]), .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_opcode(a_opcode), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
    .out_func3(a_func3), .out_func7(a_func7), .out_shamt(a_shamt), .out_imm(a_imm),
    .out_instr_id(a_id), .out_illegal(a_illegal), .count(a_count));

  decode_queue #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_opcode(b_opcode), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
    .out_func3(b_func3), .out_func7(b_func7), .out_shamt(b_shamt), .out_imm(b_imm),
    .out_instr_id(b_id), .out_illegal(b_illegal), .count(b_count));

  int checks = 0;
  int failures = 0;

  typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] mask; logic [31:0] match; logic [5:0] id; int xl; } pat_t;
  ent_t q[$];
  bit   model_ov;
  ent_t oe;
  pat_t pats[$];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic addp(logic [31:0] mask, logic [31:0] match, logic [5:0] id, int xl);
    pats.push_back('{mask, match, id, xl});
  endtask

  task automatic init_pats();
    addp(32'h7F, 32'h37, i_lui, 0); addp(32'h7F, 32'h17, i_auipc, 0); addp(32'h7F, 32'h6F, i_jal, 0);
    addp(32'h707F, 32'h67, i_jalr, 0);
    addp(32'h707F, 32'h0063, i_beq, 0); addp(32'h707F, 32'h1063, i_bne, 0);
    addp(32'h707F, 32'h4063, i_blt, 0); addp(32'h707F, 32'h5063, i_bge, 0);
    addp(32'h707F, 32'h6063, i_bltu, 0); addp(32'h707F, 32'h7063, i_bgeu, 0);
    addp(32'h707F, 32'h0003, i_lb, 0); addp(32'h707F, 32'h1003, i_lh, 0); addp(32'h707F, 32'h2003, i_lw, 0);
    addp(32'h707F, 32'h4003, i_lbu, 0); addp(32'h707F, 32'h5003, i_lhu, 0);
    addp(32'h707F, 32'h3003, i_ld, 64); addp(32'h707F, 32'h6003, i_lwu, 64);
    addp(32'h707F, 32'h0023, i_sb, 0); addp(32'h707F, 32'h1023, i_sh, 0); addp(32'h707F, 32'h2023, i_sw, 0);
    addp(32'h707F, 32'h3023, i_sd, 64);
    addp(32'h707F, 32'h0013, i_addi, 0); addp(32'h707F, 32'h2013, i_slti, 0);
    addp(32'h707F, 32'h3013, i_sltiu, 0); addp(32'h707F, 32'h4013, i_xori, 0);
    addp(32'h707F, 32'h6013, i_ori, 0); addp(32'h707F, 32'h7013, i_andi, 0);
    addp(32'hFE00707F, 32'h1013, i_slli, 32); addp(32'hFE00707F, 32'h5013, i_srli, 32);
    addp(32'hFE00707F, 32'h40005013, i_srai, 32);
    addp(32'hFC00707F, 32'h1013, i_slli, 64); addp(32'hFC00707F, 32'h5013, i_srli, 64);
    addp(32'hFC00707F, 32'h40005013, i_srai, 64);
    addp(32'hFE00707F, 32'h0033, i_add, 0); addp(32'hFE00707F, 32'h40000033, i_sub, 0);
    addp(32'hFE00707F, 32'h1033, i_sll, 0); addp(32'hFE00707F, 32'h2033, i_slt, 0);
    addp(32'hFE00707F, 32'h3033, i_sltu, 0); addp(32'hFE00707F, 32'h4033, i_xor, 0);
    addp(32'hFE00707F, 32'h5033, i_srl, 0); addp(32'hFE00707F, 32'h40005033, i_sra, 0);
    addp(32'hFE00707F, 32'h6033, i_or, 0); addp(32'hFE00707F, 32'h7033, i_and, 0);
    addp(32'h707F, 32'h000F, i_fence, 0);
    addp(32'hFFFFFFFF, 32'h00000073, i_ecall, 0); addp(32'hFFFFFFFF, 32'h00100073, i_ebreak, 0);
    addp(32'h707F, 32'h1073, i_csrrw, 0); addp(32'h707F, 32'h2073, i_csrrs, 0);
    addp(32'h707F, 32'h3073, i_csrrc, 0); addp(32'h707F, 32'h5073, i_csrrwi, 0);
    addp(32'h707F, 32'h6073, i_csrrsi, 0); addp(32'h707F, 32'h7073, i_csrrci, 0);
  endtask

  function automatic logic [5:0] ref_id(logic [31:0] w, int xl);
    foreach (pats[k])
      if ((pats[k].xl == 0 || pats[k].xl == xl) && ((w & pats[k].mask) == pats[k].match))
        return pats[k].id;
    return i_invalid;
  endfunction

  // Immediate value as a signed integer, from the format implied by the opcode
  function automatic longint ref_imm(logic [31:0] w);
    longint v;
    case (w[6:0])
      7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: begin v = w[31:20]; if (w[31]) v -= 4096; end
      7'h23: begin v = {w[31:25], w[11:7]}; if (w[31]) v -= 4096; end
      7'h63: begin v = {w[31], w[7], w[30:25], w[11:8], 1'b0}; if (w[31]) v -= 8192; end
      7'h6F: begin v = {w[31], w[19:12], w[20], w[30:21], 1'b0}; if (w[31]) v -= 64'd2097152; end
      7'h37, 7'h17: begin v = {w[31:12], 12'b0}; if (w[31]) v -= 64'h1_0000_0000; end
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] gen_instr();
    int unsigned k;
    if ($urandom_range(3) == 0) return $urandom;
    k = $urandom_range(pats.size() - 1);
    return pats[k].match | ($urandom & ~pats[k].mask);
  endfunction

  task automatic model_step(bit iv, logic [31:0] w, logic [63:0] pc, bit fl, bit ordy);
    bit inr;
    if (fl) begin
      q.delete();
      model_ov = 1'b0;
    end else begin
      inr = (q.size() < DEPTH);
      if (q.size() > 0 && (!model_ov || ordy)) begin
        oe = q.pop_front();
        model_ov = 1'b1;
      end else if (model_ov && ordy) begin
        model_ov = 1'b0;
      end
      if (iv && inr) q.push_back('{pc, w});
    end
  endtask

  task automatic check_one(string n, int xl, logic [63:0] ir, logic [63:0] ov, logic [63:0] pc,
                           logic [63:0] opc, logic [63:0] rd, logic [63:0] rs1, logic [63:0] rs2,
                           logic [63:0] f3, logic [63:0] f7, logic [63:0] sh, logic [63:0] imm,
                           logic [63:0] id, logic [63:0] ill, logic [63:0] cnt);
    logic [63:0] xm;
    logic [31:0] w;
    logic [5:0]  eid;
    xm = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    chk({n, ".in_ready"}, ir, 64'(q.size() < DEPTH));
    chk({n, ".count"}, cnt, 64'(q.size()));
    chk({n, ".out_valid"}, ov, 64'(model_ov));
    if (model_ov) begin
      w   = oe.instr;
      eid = ref_id(w, xl);
      chk({n, ".pc"}, pc, oe.pc & xm);
      chk({n, ".opcode"}, opc, 64'(w[6:0]));
      chk({n, ".rd"}, rd, 64'(w[11:7]));
      chk({n, ".rs1"}, rs1, 64'(w[19:15]));
      chk({n, ".rs2"}, rs2, 64'(w[24:20]));
      chk({n, ".func3"}, f3, 64'(w[14:12]));
      chk({n, ".func7"}, f7, 64'(w[31:25]));
      chk({n, ".shamt"}, sh, (xl == 64) ? 64'(w[25:20]) : 64'(w[24:20]));
      chk({n, ".id"}, id, 64'(eid));
      chk({n, ".illegal"}, ill, 64'(eid == i_invalid));
      if (eid != i_invalid) chk({n, ".imm"}, imm, 64'(ref_imm(w)) & xm);
    end
  endtask

  task automatic check_all();
    check_one("x32", 32, 64'(a_in_ready), 64'(a_out_valid), 64'(a_pc), 64'(a_opcode), 64'(a_rd),
              64'(a_rs1), 64'(a_rs2), 64'(a_func3), 64'(a_func7), 64'(a_shamt), 64'(a_imm),
              64'(a_id), 64'(a_illegal), 64'(a_count));
    check_one("x64", 64, 64'(b_in_ready), 64'(b_out_valid), b_pc, 64'(b_opcode), 64'(b_rd),
              64'(b_rs1), 64'(b_rs2), 64'(b_func3), 64'(b_func7), 64'(b_shamt), b_imm,
              64'(b_id), 64'(b_illegal), 64'(b_count));
  endtask

  task automatic check_reset(string n);
    chk({n, ".in_ready"}, 64'(a_in_ready & b_in_ready), 64'd1);
    chk({n, ".out_valid"}, 64'(a_out_valid | b_out_valid), 64'd0);
    chk({n, ".count"}, 64'(a_count | b_count), 64'd0);
    chk({n, ".pc_imm"}, 64'(a_pc) | 64'(a_imm) | b_pc | b_imm, 64'd0);
    chk({n, ".fields"}, 64'({a_opcode, a_rd, a_rs1, a_rs2, a_func3, a_func7, a_shamt, a_id,
                             b_opcode, b_rd, b_rs1, b_rs2, b_func3, b_func7, b_shamt, b_id}), 64'd0);
    chk({n, ".illegal"}, 64'(a_illegal | b_illegal), 64'd0);
  endtask

  task automatic cycle(bit iv, logic [31:0] w, logic [63:0] pc, bit fl, bit ordy);
    in_valid = iv; in_instr = w; in_pc = pc; flush = fl; out_ready = ordy;
    model_step(iv, w, pc, fl, ordy);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(int n);
    repeat (n) cycle(1'b0, 32'd0, 64'd0, 1'b0, 1'b1);
  endtask

  function automatic logic [63:0] rand_pc();
    return {$urandom, $urandom} & ~64'h3;
  endfunction

  // Push one word, let it reach the output register, then compare ids against constants
  task automatic directed(string n, logic [31:0] w, logic [5:0] id32, logic [5:0] id64);
    cycle(1'b1, w, 64'h200, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 64'd0, 1'b0, 1'b1);
    chk({n, ".id32"}, 64'(a_id), 64'(id32));
    chk({n, ".id64"}, 64'(b_id), 64'(id64));
    chk({n, ".ill32"}, 64'(a_illegal), 64'(id32 == i_invalid));
    chk({n, ".ill64"}, 64'(b_illegal), 64'(id64 == i_invalid));
    idle(1);
  endtask

  initial begin
    int acc;
    init_pats();
    q.delete();
    model_ov = 1'b0;
    rst_n = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all();

    // addi x1,x2,-1 at 0x100 into an idle block
    cycle(1'b1, 32'hFFF10093, 64'h100, 1'b0, 1'b1);
    chk("addi.early", 64'(a_out_valid), 64'd0);
    cycle(1'b0, 32'd0, 64'd0, 1'b0, 1'b1);
    chk("addi.valid", 64'(a_out_valid & b_out_valid), 64'd1);
    chk("addi.id", 64'(a_id), 64'(i_addi));
    chk("addi.rd", 64'(a_rd), 64'd1);
    chk("addi.rs1", 64'(b_rs1), 64'd2);
    chk("addi.imm32", 64'(a_imm), 64'hFFFF_FFFF);
    chk("addi.imm64", b_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi.pc", b_pc, 64'h100);
    idle(2);

    // Backpressure: push DEPTH+2 with out_ready low, then drain across pointer wrap
    acc = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (a_in_ready) acc++;
      cycle(1'b1, gen_instr(), rand_pc(), 1'b0, 1'b0);
    end
    chk("bp.accepts", 64'(acc), 64'(DEPTH + 1));
    chk("bp.count", 64'(a_count), 64'(DEPTH));
    chk("bp.in_ready", 64'(a_in_ready | b_in_ready), 64'd0);
    cycle(1'b1, gen_instr(), rand_pc(), 1'b0, 1'b1);
    chk("bp.full_pop_no_push", 64'(a_count), 64'(DEPTH - 1));
    idle(DEPTH + 3);

    // Streaming
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, gen_instr(), rand_pc(), 1'b0, 1'b1);
      chk("stream.count_le1", 64'(a_count <= 1), 64'd1);
      if (i > 1) chk("stream.valid", 64'(a_out_valid), 64'd1);
    end
    idle(3);

    // Flush with 3 buffered, 1 in output register and a presented instruction
    for (int i = 0; i < 4; i++) cycle(1'b1, gen_instr(), rand_pc(), 1'b0, 1'b0);
    chk("flush.pre_count", 64'(a_count), 64'd3);
    cycle(1'b1, 32'hFFF10093, 64'h300, 1'b1, 1'b1);
    chk("flush.valid", 64'(a_out_valid | b_out_valid), 64'd0);
    chk("flush.count", 64'(a_count | b_count), 64'd0);
    idle(3);

    // XLEN-dependent and SYSTEM encodings
    directed("slli25", 32'h02009093, i_invalid, i_slli);
    cycle(1'b1, 32'h02009093, 64'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 64'd0, 1'b0, 1'b1);
    chk("slli25.shamt64", 64'(b_shamt), 64'd32);
    idle(1);
    directed("sd", 32'h00113023, i_invalid, i_sd);
    directed("ebreak", 32'h00100073, i_ebreak, i_ebreak);
    directed("ecall", 32'h00000073, i_ecall, i_ecall);
    directed("sys_bad", 32'h00200073, i_invalid, i_invalid);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(99) < 70), gen_instr(), rand_pc(), ($urandom_range(99) < 4),
            ($urandom_range(99) < ((i < 300) ? 40 : 85)));

    // Async reset mid-stream
    for (int i = 0; i < 3; i++) cycle(1'b1, gen_instr(), rand_pc(), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset("async_rst");
    q.delete();
    model_ov = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_reset("async_rst_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++)
      cycle(($urandom_range(99) < 70), gen_instr(), rand_pc(), 1'b0, ($urandom_range(99) < 60));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
